// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch types (package common); FETCH_MISALIGN_CHECK_EN adds the misaligned flag
package common;

    typedef logic [31:0] instruction_type;

    localparam instruction_type NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        instruction_type instruction;
        logic [31:0]     pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        logic            misaligned;
`endif
    } fetch_entry_type;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response channel
interface fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_stage_queue.sv
// rtl/fetch_stage_queue.sv - fetch_queue: synchronous FIFO of fetch entries, flush has priority
module fetch_queue
    import common::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_type        i_push_entry,
    output fetch_entry_type        o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_type r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_entry;
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, credit and redirect logic of the fetch stage
// FETCH_MISALIGN_CHECK_EN tags the first entry after a misaligned redirect.
module fetch_stage
    import common::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    fetch_stage_if.master   imem,
    input  logic            redirect_en,
    input  logic [31:0]     redirect_pc,
    input  logic            stall,
    output instruction_type instruction,
    output logic [31:0]     pc_out,
    output logic            instruction_valid,
    output logic            fetch_misaligned
);

    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [IW-1:0]   r_inflight;
    logic [IW-1:0]   r_drop_count;
    logic [CW-1:0]   w_count;
    logic [31:0]     w_credit;
    logic [31:0]     w_target;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_fire;
    fetch_entry_type w_head;
    fetch_entry_type w_push_entry;

    assign w_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_pop    = !w_empty && !stall;
    // Every issued request must already own a queue slot for its response.
    assign w_credit = 32'(r_inflight) + 32'(w_count) - 32'(w_pop);

    assign imem.imem_req_valid = !reset && !redirect_en
                              && (32'(r_inflight) < 32'(MAX_OUTSTANDING))
                              && (w_credit < 32'(QUEUE_DEPTH));
    assign imem.imem_req_addr  = r_fetch_pc;
    assign w_fire = imem.imem_req_valid && imem.imem_req_ready;
    assign w_push = imem.imem_rsp_valid && (r_drop_count == '0) && !redirect_en && !w_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc   <= RESET_PC;
            r_rsp_pc     <= RESET_PC;
            r_inflight   <= '0;
            r_drop_count <= '0;
        end else begin
            r_inflight <= r_inflight + IW'(w_fire) - IW'(imem.imem_rsp_valid);
            if (redirect_en) begin
                r_fetch_pc   <= w_target;
                r_rsp_pc     <= w_target;
                r_drop_count <= r_inflight - IW'(imem.imem_rsp_valid);
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
                if (imem.imem_rsp_valid && (r_drop_count != '0))
                    r_drop_count <= r_drop_count - IW'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_mis_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_mis_pending <= 1'b0;
        else if (redirect_en) r_mis_pending <= (redirect_pc[1:0] != 2'b00);
        else if (w_push)      r_mis_pending <= 1'b0;
    end

    assign fetch_misaligned = !w_empty && w_head.misaligned;
`else
    assign fetch_misaligned = 1'b0;
`endif

    always_comb begin
        w_push_entry             = '0;
        w_push_entry.instruction = imem.imem_rsp_data;
        w_push_entry.pc          = r_rsp_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        w_push_entry.misaligned  = r_mis_pending;
`endif
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (redirect_en),
        .i_push_entry (w_push_entry),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    assign instruction_valid = !w_empty;
    assign instruction       = w_empty ? NOP_INSTRUCTION : w_head.instruction;
    assign pc_out            = w_empty ? 32'h0 : w_head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage; honours FETCH_MISALIGN_CHECK_EN
module tb_fetch_stage;
    import common::*;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            stall;
    logic            redirect_en;
    logic [31:0]     redirect_pc;
    instruction_type instruction, instruction2;
    logic [31:0]     pc_out, pc_out2;
    logic            instruction_valid, valid2;
    logic            fetch_misaligned, mis2;

    fetch_stage_if imem ();
    fetch_stage_if imem2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem(imem),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .stall(stall),
        .instruction(instruction), .pc_out(pc_out),
        .instruction_valid(instruction_valid), .fetch_misaligned(fetch_misaligned)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .imem(imem2),
        .redirect_en(1'b0), .redirect_pc(32'h0), .stall(1'b0),
        .instruction(instruction2), .pc_out(pc_out2),
        .instruction_valid(valid2), .fetch_misaligned(mis2)
    );

    typedef struct {
        logic        stall;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    vec_t        tbl [11];
    logic [31:0] wrap_addr [3];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          lat = 1;
    logic        pipe_v [8];
    logic [31:0] pipe_a [8];
    logic        hs, hs2;
    logic [31:0] ha, ha2;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_load(input logic [31:0] start, input int n, input logic first_mis);
        sb.delete();
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc   = start + 32'(4 * i);
            e.data = ~e.pc;
            e.mis  = (i == 0) && first_mis;
            sb.push_back(e);
        end
    endtask

    // Called at the negedge: scoreboard pop, handshake capture, then memory advance after the edge.
    task automatic finish_cycle();
        exp_t e;
        if (instruction_valid && !stall) begin
            n_pops++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_extra: got pc %h expected no instruction", pc_out);
            end else begin
                e = sb.pop_front();
                check32("sb_pc", pc_out, e.pc);
                check32("sb_instr", instruction, e.data);
                check1("sb_mis", fetch_misaligned, e.mis);
            end
        end
        hs  = imem.imem_req_valid && imem.imem_req_ready;
        ha  = imem.imem_req_addr;
        hs2 = imem2.imem_req_valid && imem2.imem_req_ready;
        ha2 = imem2.imem_req_addr;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            pipe_v[i] = pipe_v[i+1];
            pipe_a[i] = pipe_a[i+1];
        end
        pipe_v[7] = 1'b0;
        if (hs) begin
            pipe_v[lat-1] = 1'b1;
            pipe_a[lat-1] = ha;
        end
        imem.imem_rsp_valid  = pipe_v[0];
        imem.imem_rsp_data   = ~pipe_a[0];
        imem2.imem_rsp_valid = hs2;
        imem2.imem_rsp_data  = ~ha2;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = 32'h0;
        end
        imem.imem_rsp_valid  = 1'b0;
        imem.imem_rsp_data   = 32'h0;
        imem2.imem_rsp_valid = 1'b0;
        imem2.imem_rsp_data  = 32'h0;
        n_pops = 0;
        @(negedge clk);
        check1("rst_req_valid", imem.imem_req_valid, 1'b0);
        check1("rst_valid", instruction_valid, 1'b0);
        check32("rst_instr", instruction, NOP_INSTRUCTION);
        check32("rst_pc_out", pc_out, 32'h0);
        check1("rst_mis", fetch_misaligned, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        //            stall  rv    addr          valid pc_out
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[7]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[8]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[9]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[10] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;
        imem.imem_req_ready  = 1'b1;
        imem2.imem_req_ready = 1'b1;

        // Sequential fetch with a 3-cycle stall, plus the wrap-around instance.
        lat = 1;
        do_reset();
        sb_load(32'h0, 16, 1'b0);
        for (int c = 0; c < 11; c++) begin
            stall = tbl[c].stall;
            @(negedge clk);
            check1("seq_req_valid", imem.imem_req_valid, tbl[c].exp_rv);
            if (tbl[c].exp_rv) check32("seq_req_addr", imem.imem_req_addr, tbl[c].exp_addr);
            check1("seq_valid", instruction_valid, tbl[c].exp_valid);
            check32("seq_pc_out", pc_out, tbl[c].exp_pc);
            if (c < 3) check32("wrap_addr", imem2.imem_req_addr, wrap_addr[c]);
            if (c >= 2 && c <= 4) begin
                check1("wrap_valid", valid2, 1'b1);
                check32("wrap_pc", pc_out2, wrap_addr[c-2]);
                check32("wrap_instr", instruction2, ~wrap_addr[c-2]);
                check1("wrap_mis", mis2, 1'b0);
            end
            finish_cycle();
        end
        stall = 1'b0;
        check32("seq_pop_count", 32'(n_pops), 32'd6);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        do_reset();
        sb.delete();
        for (int c = 0; c < 13; c++) begin
            redirect_en = (c == 2);
            redirect_pc = 32'h0000_0100;
            @(negedge clk);
            if (c == 2) sb_load(32'h100, 8, 1'b0);
            if (c == 3) check1("drop_valid_after", instruction_valid, 1'b0);
            if (c == 4) begin
                check1("drop_req_valid", imem.imem_req_valid, 1'b1);
                check32("drop_req_addr", imem.imem_req_addr, 32'h100);
            end
            finish_cycle();
        end
        redirect_en = 1'b0;
        check32("drop_pop_count", 32'(n_pops), 32'd3);

        // Redirect coinciding with stall and a response.
        lat = 1;
        do_reset();
        sb_load(32'h0, 16, 1'b0);
        for (int c = 0; c < 9; c++) begin
            stall       = (c == 4);
            redirect_en = (c == 4);
            redirect_pc = 32'h0000_0200;
            @(negedge clk);
            if (c == 4) sb_load(32'h200, 8, 1'b0);
            if (c == 5) begin
                check1("rdst_valid", instruction_valid, 1'b0);
                check1("rdst_req_valid", imem.imem_req_valid, 1'b1);
                check32("rdst_req_addr", imem.imem_req_addr, 32'h200);
            end
            finish_cycle();
        end
        stall       = 1'b0;
        redirect_en = 1'b0;
        check32("rdst_pop_count", 32'(n_pops), 32'd4);

        // Misaligned redirect target.
        lat = 1;
        do_reset();
        sb_load(32'h0, 16, 1'b0);
        for (int c = 0; c < 6; c++) begin
            redirect_en = (c == 1);
            redirect_pc = 32'h0000_0102;
            @(negedge clk);
            if (c == 1) sb_load(32'h100, 8, MIS_EN);
            if (c == 2) begin
                check1("mis_req_valid", imem.imem_req_valid, 1'b1);
                check32("mis_req_addr", imem.imem_req_addr, 32'h100);
            end
            finish_cycle();
        end
        redirect_en = 1'b0;
        check32("mis_pop_count", 32'(n_pops), 32'd2);

        // Asynchronous reset in the middle of streaming.
        lat = 1;
        do_reset();
        sb_load(32'h0, 16, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            finish_cycle();
        end
        check1("mid_valid_before", instruction_valid, 1'b1);
        reset = 1'b1;
        #1;
        check1("mid_req_valid", imem.imem_req_valid, 1'b0);
        check1("mid_valid", instruction_valid, 1'b0);
        check32("mid_instr", instruction, NOP_INSTRUCTION);
        check32("mid_pc_out", pc_out, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check1("mid_restart_req", imem.imem_req_valid, 1'b1);
        check32("mid_restart_addr", imem.imem_req_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RISC-V pipeline. It owns the program counter and issues word requests to instruction memory over a valid/ready request channel. In-order responses land in a small queue, which drives decode with `instruction`, `pc_out` and a valid flag. It honours decode stalls and execute-stage redirects, including discarding responses that are still in flight when a redirect happens.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `QUEUE_DEPTH`, default 2: instruction queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, default 2: maximum issued requests without a response.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  request present.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word address; bits [1:0] are always 0.
- `imem_rsp_valid`  in  1  response present; in order, exactly one per accepted request, no backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_en`  in  1  taken branch or jump from execute.
- `redirect_pc`  in  32  new fetch target.
- `stall`  in  1  decode cannot accept; hold the head entry.
- `instruction`  out  32 (instruction_type)  head instruction; NOP when not valid.
- `pc_out`  out  32  PC of the head instruction.
- `instruction_valid`  out  1  head entry is valid.
- `fetch_misaligned`  out  1  head entry came from a misaligned redirect (see Configuration).

## Operation
- Registers:
  - `fetch_pc`: next request address.
  - `rsp_pc`: PC of the next non-dropped response.
  - `inflight`: accepted requests not yet answered.
  - `drop_count`: responses still to discard.
  - The queue.
- Issue condition: `imem_req_valid` = !`redirect_en` && `inflight` < `MAX_OUTSTANDING` && (`inflight` + `queue_count` − `pop`) < `QUEUE_DEPTH`. This guarantees a free slot for every response.
- `imem_req_addr` = `fetch_pc`. On `imem_req_valid` && `imem_req_ready`: `fetch_pc` += 4 and `inflight` += 1.
- A request is committed only on handshake. `imem_req_valid` may drop without a handshake (redirect), and memory must tolerate this.
- Response handling:
  - `inflight` −= 1.
  - If `drop_count` > 0: discard the response and decrement `drop_count`.
  - Otherwise: push {`imem_rsp_data`, `rsp_pc`, flag} into the queue and `rsp_pc` += 4.
- Pop: `instruction_valid` && !`stall`.
- When the queue is empty: `instruction` = 32'h0000_0013, `pc_out` = 0, `instruction_valid` = 0.
- Redirect (`redirect_en` = 1):
  - Queue flushed.
  - `fetch_pc` and `rsp_pc` take `redirect_pc` with [1:0] cleared.
  - `drop_count` ← `inflight` − `imem_rsp_valid`; any response arriving that cycle is discarded.
  - No request is issued that cycle.
- Address arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `imem_req_valid` 0 while `reset` is high, `fetch_pc` = `RESET_PC`, `rsp_pc` = `RESET_PC`, counters 0, queue empty, `instruction` NOP, `pc_out` 0, `instruction_valid` 0, `fetch_misaligned` 0.
- The first cycle after reset deasserts: `imem_req_valid` = 1 with `RESET_PC`.
- Response in cycle N: `instruction_valid` = 1 in cycle N+1 (queue registered).
- With 1-cycle memory, always ready and no stall: one instruction per cycle sustained from cycle 2.
- Redirect in cycle N:
  - `instruction_valid` = 0 in N+1.
  - Request to `redirect_pc` in N+1.
- Simultaneous events:
  - Redirect beats stall, pop and push.
  - Push and pop in the same cycle keep the occupancy unchanged.
  - Stall with a full queue holds the head, and issue stops through the credit rule.
- Reset mid-operation clears all state immediately. Memory shares `reset`, so no stale responses follow reset.

## Configuration
- Macro `FETCH_MISALIGN_CHECK_EN`:
  - Defined: redirect_pc[1:0] ≠ 0 tags the first queued instruction after that redirect with `fetch_misaligned` = 1, presented alongside `instruction_valid`. Decode ORs it into the illegal-instruction path.
  - Undefined: low bits are silently cleared, the flag storage is removed and `fetch_misaligned` is tied to 0.

## Structure
- Shared package `common`:
  - `instruction_type` (existing).
  - `NOP_INSTRUCTION` = 32'h0000_0013.
  - `fetch_entry_type` struct {instruction, pc, misaligned}.
- Sub-module `fetch_queue`:
  - Parameterized synchronous FIFO of `fetch_entry_type`.
  - Ports: push, pop, flush (flush has priority), count, head output, full/empty.
- `fetch_stage` holds the PC, counter, credit and redirect logic.

## Test plan
- Reset release, 1-cycle memory always ready → requests 0x0, 0x4, 0x8 in cycles 0, 1, 2; `instruction_valid` from cycle 2 with `pc_out` 0x0, 0x4, 0x8 back-to-back.
- `stall` high for 3 cycles with the head at pc 0x8 → `pc_out` holds 0x8; `imem_req_valid` drops once `inflight` + count = 2; no instruction is lost or duplicated after release.
- 3-cycle memory latency, redirect to 0x100 while 2 requests are in flight → both stale responses discarded; the next valid instruction has `pc_out` 0x100 and its data from address 0x100.
- Redirect in the same cycle as `stall` and a response → queue empty next cycle; the response is dropped; a request to the target follows in the next cycle.
- PC wrap: `RESET_PC` = 32'hFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x102 → request address 0x100; the first valid entry has `fetch_misaligned` = 1 and the next entry 0. Without the macro, `fetch_misaligned` stays 0.
